// File: rtl/mode_ctrl_fsm.sv
// ============================================================================
// Module   : mode_ctrl_fsm (with helper mode_ctrl_btn_cls)
// Brief    : Button press classifier and display-mode / control decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mode_ctrl_btn_cls #(
  parameter int LONG_CNT   = 1000,
  parameter int REPEAT_CNT = 200,
  parameter int EN_REPEAT  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [1:0] evt
);
  localparam int CW = $clog2(LONG_CNT + 1);
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'(REPEAT_CNT - 1);

  localparam logic [1:0] EVT_NONE  = 2'd0;
  localparam logic [1:0] EVT_SHORT = 2'd1;
  localparam logic [1:0] EVT_LONG  = 2'd2;
  localparam logic [1:0] EVT_RPT   = 2'd3;

  typedef enum logic [1:0] {ST_DISARM, ST_IDLE, ST_HELD, ST_LONG} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [1:0]    evt_q, evt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rep_d   = rep_q;
    evt_d   = EVT_NONE;
    case (state_q)
      // a button held through reset must be seen low before it can arm
      ST_DISARM: if (!btn) state_d = ST_IDLE;
      ST_IDLE: begin
        if (btn) begin
          cnt_d   = CW'(1);
          state_d = ST_HELD;
        end
      end
      ST_HELD: begin
        if (!btn) begin
          evt_d   = EVT_SHORT;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LONG_LAST) begin
            evt_d   = EVT_LONG;
            rep_d   = '0;
            state_d = ST_LONG;
          end
        end
      end
      ST_LONG: begin
        if (!btn) begin
          cnt_d   = '0;
          rep_d   = '0;
          state_d = ST_IDLE;
        end else if (EN_REPEAT != 0) begin
          if (rep_q == RPT_LAST) begin
            evt_d = EVT_RPT;
            rep_d = '0;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
      end
      default: state_d = ST_DISARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_DISARM;
      cnt_q   <= '0;
      rep_q   <= '0;
      evt_q   <= EVT_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      evt_q   <= evt_d;
    end
  end

  assign evt = evt_q;
endmodule

module mode_ctrl_fsm #(
  parameter int NUM_MODES  = 3,
  parameter int NUM_FIELDS = 2,
  parameter int LONG_CNT   = 1000,
  parameter int REPEAT_CNT = 200,
  localparam int MW = (NUM_MODES  > 2) ? $clog2(NUM_MODES)  : 1,
  localparam int FW = (NUM_FIELDS > 2) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          btn_mode,
  input  logic          btn_l,
  input  logic          btn_r,
  output logic [MW-1:0] mode_sel,
  output logic          running,
  output logic          lap_hold,
  output logic          setting,
  output logic [FW-1:0] field_sel,
  output logic          inc_pulse,
  output logic          clr_pulse
);
  localparam logic [1:0] EVT_NONE  = 2'd0;
  localparam logic [1:0] EVT_SHORT = 2'd1;
  localparam logic [1:0] EVT_LONG  = 2'd2;
  localparam logic [1:0] EVT_RPT   = 2'd3;
  localparam logic [MW-1:0] MODE_LAST  = MW'(NUM_MODES - 1);
  localparam logic [FW-1:0] FIELD_LAST = FW'(NUM_FIELDS - 1);

  logic [2:0] btn_vec;
  logic [1:0] evt [3];
  assign btn_vec = {btn_r, btn_l, btn_mode};

  // index 0 = mode, 1 = left, 2 = right; only the right button auto-repeats
  for (genvar gi = 0; gi < 3; gi++) begin : g_cls
    mode_ctrl_btn_cls #(
      .LONG_CNT  (LONG_CNT),
      .REPEAT_CNT(REPEAT_CNT),
      .EN_REPEAT ((gi == 2) ? 1 : 0)
    ) u_cls (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_vec[gi]),
      .evt  (evt[gi])
    );
  end

  logic [MW-1:0] mode_q, mode_d;
  logic [FW-1:0] field_q, field_d;
  logic          running_q, running_d, lap_q, lap_d, setting_q, setting_d;
  logic          inc_q, inc_d, clr_q, clr_d;

  always_comb begin
    mode_d    = mode_q;
    field_d   = field_q;
    running_d = running_q;
    lap_d     = lap_q;
    setting_d = setting_q;
    inc_d     = 1'b0;
    clr_d     = 1'b0;
    if (evt[0] != EVT_NONE) begin
      mode_d    = (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
      setting_d = 1'b0;
      field_d   = '0;
    end else if (mode_q == '0) begin
      if (evt[2] == EVT_SHORT) running_d = ~running_q;
      if (evt[1] == EVT_SHORT) begin
        if (running_q)  lap_d = ~lap_q;
        else if (lap_q) lap_d = 1'b0;
        else            clr_d = 1'b1;
      end
    end else begin
      if (setting_q) begin
        if (evt[2] == EVT_SHORT || evt[2] == EVT_RPT) inc_d = 1'b1;
        if (evt[1] == EVT_SHORT)
          field_d = (field_q == FIELD_LAST) ? '0 : field_q + FW'(1);
      end
      if (evt[2] == EVT_LONG) begin
        setting_d = ~setting_q;
        field_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mode_q    <= '0;
      field_q   <= '0;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      setting_q <= 1'b0;
      inc_q     <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      field_q   <= field_d;
      running_q <= running_d;
      lap_q     <= lap_d;
      setting_q <= setting_d;
      inc_q     <= inc_d;
      clr_q     <= clr_d;
    end
  end

  assign mode_sel  = mode_q;
  assign running   = running_q;
  assign lap_hold  = lap_q;
  assign setting   = setting_q;
  assign field_sel = field_q;
  assign inc_pulse = inc_q;
  assign clr_pulse = clr_q;
endmodule

`default_nettype wire

// File: tb/tb_mode_ctrl_fsm.sv
// ============================================================================
// Module   : tb_mode_ctrl_fsm
// Brief    : Directed self-checking bench for mode_ctrl_fsm (LONG_CNT=8, REPEAT_CNT=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mode_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_mode = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic [1:0] mode_sel;
  logic       running, lap_hold, setting, inc_pulse, clr_pulse;
  logic       field_sel;
  int         n_cmp = 0;
  int         n_err = 0;

  mode_ctrl_fsm #(
    .NUM_MODES (3),
    .NUM_FIELDS(2),
    .LONG_CNT  (8),
    .REPEAT_CNT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_l    (btn_l),
    .btn_r    (btn_r),
    .mode_sel (mode_sel),
    .running  (running),
    .lap_hold (lap_hold),
    .setting  (setting),
    .field_sel(field_sel),
    .inc_pulse(inc_pulse),
    .clr_pulse(clr_pulse)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // hold a button for n sampled edges, release, then advance to release edge + 1
  task automatic press(input int b, input int n);
    if (b == 0) btn_mode = 1'b1; else if (b == 1) btn_l = 1'b1; else btn_r = 1'b1;
    step(n);
    btn_mode = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    step(2);
  endtask

  initial begin
    step(2);
    chk("rst_mode", 32'(mode_sel), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_lap", 32'(lap_hold), 0);
    chk("rst_set", 32'(setting), 0);
    chk("rst_field", 32'(field_sel), 0);
    chk("rst_pulses", {30'd0, inc_pulse, clr_pulse}, 0);
    rst_n = 1'b0;
    step(2);

    // mode cycling with latency check on the first press
    btn_mode = 1'b1; step(2); btn_mode = 1'b0;
    step(1); chk("mode_lat_E", 32'(mode_sel), 0);
    step(1); chk("mode_1", 32'(mode_sel), 1);
    press(0, 2); chk("mode_2", 32'(mode_sel), 2);
    press(0, 2); chk("mode_wrap0", 32'(mode_sel), 0);

    // stopwatch mode
    press(2, 3); chk("sw_run_on", 32'(running), 1);
    press(1, 3); chk("sw_lap_on", 32'(lap_hold), 1);
    chk("sw_lap_noclr", 32'(clr_pulse), 0);
    press(1, 2); chk("sw_lap_off", 32'(lap_hold), 0);
    press(2, 2); chk("sw_run_off", 32'(running), 0);
    press(1, 2); chk("sw_clr_on", 32'(clr_pulse), 1);
    chk("sw_clr_lap", 32'(lap_hold), 0);
    step(1); chk("sw_clr_off", 32'(clr_pulse), 0);
    press(2, 12); chk("sw_long_ign", 32'(running), 0);
    chk("sw_long_mode", 32'(mode_sel), 0);
    press(2, 2); chk("sw_run_on2", 32'(running), 1);

    // clock mode 1: long press enters setting, then auto-repeat
    press(0, 2); chk("clk_mode1", 32'(mode_sel), 1);
    btn_r = 1'b1;
    step(8); chk("set_pre", 32'(setting), 0);
    step(1); chk("set_on", 32'(setting), 1);
    chk("set_no_inc", 32'(inc_pulse), 0);
    for (int k = 10; k <= 21; k++) begin
      step(1);
      chk($sformatf("rpt_inc_e%0d", k), 32'(inc_pulse),
          (k == 13 || k == 17 || k == 21) ? 32'd1 : 32'd0);
      if (k == 20) btn_r = 1'b0;
    end
    step(2); chk("set_hold", 32'(setting), 1);
    press(1, 2); chk("field_1", 32'(field_sel), 1);
    press(1, 2); chk("field_wrap", 32'(field_sel), 0);
    press(2, 2); chk("set_short_inc", 32'(inc_pulse), 1);
    press(2, 8); chk("set_off", 32'(setting), 0);
    chk("set_off_field", 32'(field_sel), 0);
    press(2, 2); chk("idle_short_noinc", 32'(inc_pulse), 0);
    press(1, 2); chk("idle_l_nofield", 32'(field_sel), 0);

    // mode press while setting drops setting and field, keeps running
    press(2, 8); chk("set_on2", 32'(setting), 1);
    press(1, 2); chk("field_1b", 32'(field_sel), 1);
    press(0, 2); chk("mode2", 32'(mode_sel), 2);
    chk("mode2_set", 32'(setting), 0);
    chk("mode2_field", 32'(field_sel), 0);
    chk("mode2_run", 32'(running), 1);

    // simultaneous mode + left in stopwatch mode: mode wins
    press(0, 2); chk("back_mode0", 32'(mode_sel), 0);
    btn_mode = 1'b1; btn_l = 1'b1;
    step(2);
    btn_mode = 1'b0; btn_l = 1'b0;
    step(2);
    chk("simul_mode", 32'(mode_sel), 1);
    chk("simul_lap", 32'(lap_hold), 0);
    chk("simul_clr", 32'(clr_pulse), 0);
    press(0, 2); press(0, 2); chk("mode0_again", 32'(mode_sel), 0);

    // reset with a held button: no event until seen low
    btn_r = 1'b1; rst_n = 1'b1;
    step(2);
    chk("rst2_run", 32'(running), 0);
    chk("rst2_mode", 32'(mode_sel), 0);
    rst_n = 1'b0;
    step(3); btn_r = 1'b0; step(2);
    chk("disarm_short", 32'(running), 0);
    btn_r = 1'b1; rst_n = 1'b1;
    step(2); rst_n = 1'b0;
    step(20); btn_r = 1'b0; step(2);
    chk("disarm_long", 32'(running), 0);
    press(2, 2); chk("rearm_run", 32'(running), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mode_ctrl_fsm.md
Name: mode_ctrl_fsm

Overview:
- Parametrised successor to the stopwatch/clock button-to-control decoder.
- Classifies each button press as short, long or auto-repeat.
- Cycles through NUM_MODES display modes and produces toggle levels plus one-cycle command pulses for the stopwatch core and the clock-setting datapath.
- Sits between the debounce/one-pulse stage and the counter cores.

Parameters:
NUM_MODES, 3, number of modes; mode 0 = stopwatch, modes 1..NUM_MODES-1 = settable clock-type modes (legal ≥2)
NUM_FIELDS, 2, settable fields per clock mode, e.g. 0=min, 1=hour (legal ≥1)
LONG_CNT, 1000, consecutive held clk cycles that make a long press (legal ≥2)
REPEAT_CNT, 200, cycles between auto-repeat increments after a long press (legal ≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-high (name kept per codebase)
btn_mode  in  1  debounced, synchronised mode button level
btn_l  in  1  debounced left button level
btn_r  in  1  debounced right button level
mode_sel  out  MW=max(1,clog2(NUM_MODES))  current mode
running  out  1  stopwatch run level
lap_hold  out  1  stopwatch display-freeze level
setting  out  1  clock-setting active level
field_sel  out  FW=max(1,clog2(NUM_FIELDS))  field being set
inc_pulse  out  1  one-cycle increment of selected field
clr_pulse  out  1  one-cycle stopwatch clear

Behaviour:
- Reset (rst_n=1 at a clk edge): all outputs 0, all press counters 0, all buttons disarmed.
  - A button that is high when reset deasserts must be seen low once before it can register any event.
- Classifier, one per button:
  - Saturating hold counter; counts sampled-high edges.
  - Release before LONG_CNT: short event, internal and registered, asserted after the release-sampling edge E.
  - Counter reaching LONG_CNT: long event asserted once; no short event is produced on the later release.
  - btn_r after a long event, while still held: repeat event every REPEAT_CNT cycles.
  - btn_l and btn_mode generate no repeats.
- Control registers act on events at the following edge:
  - Outputs change at E+1, i.e. 2 edges after the sampling edge.
  - Pulses are exactly 1 cycle wide.
- btn_mode short or long press:
  - mode_sel := (mode_sel+1) mod NUM_MODES, wrapping NUM_MODES-1 → 0.
  - setting := 0 and field_sel := 0.
  - running and lap_hold are kept, so the stopwatch continues in the background.
- Mode 0 (stopwatch):
  - r short: toggle running.
  - l short with running=1: toggle lap_hold.
  - l short with running=0 and lap_hold=1: lap_hold := 0.
  - l short with running=0 and lap_hold=0: clr_pulse.
  - Long and repeat events are ignored.
- Mode ≠0 (clock):
  - r long: toggle setting. Entering sets field_sel := 0; exiting also clears field_sel.
  - While setting=1:
    - r short: inc_pulse.
    - Each r repeat: inc_pulse.
    - l short: field_sel := (field_sel+1) mod NUM_FIELDS.
  - While setting=0: shorts and repeats are ignored.
  - The long event that enters setting does not itself pulse inc_pulse.
- Simultaneous events in one cycle: a mode event wins and l/r events from that cycle are discarded; l and r events in the same cycle are both applied.
- Reset during a press or during setting: same as power-on reset. No event is produced for the interrupted press.
- Widths:
  - Counter width clog2(LONG_CNT+1).
  - Repeat counter width clog2(REPEAT_CNT+1).
  - No overflow: the hold counter saturates at LONG_CNT.

Test Plan:
- Run with LONG_CNT=8, REPEAT_CNT=4, NUM_MODES=3, NUM_FIELDS=2.
- Reset, then btn_mode pulsed 3 times, each 2 cycles → mode_sel 1, 2, 0; each change 2 edges after release is sampled.
- Mode 0: btn_r held 3 cycles → running=1. btn_l held 3 cycles → lap_hold=1. btn_l again → lap_hold=0. btn_r → running=0. btn_l → single 1-cycle clr_pulse. btn_r held 12 cycles → no change.
- Mode 1: btn_r held 8 cycles → setting=1, no inc_pulse. Hold continues 12 more cycles → 3 inc_pulse, 4 cycles apart. btn_l short ×2 → field_sel 1 then 0. btn_r long → setting=0.
- Mode 1 setting=1, field_sel=1: press btn_mode → mode_sel=2, setting=0, field_sel=0. running is unchanged from its earlier value (running=1 preserved).
- btn_mode and btn_l short events in the same cycle, mode 0 → mode advances, lap_hold/clr unchanged.
- Reset asserted with btn_r held; btn_r stays high 20 cycles after reset release → no event; release then short press → running toggles.
